// File: rtl/rz_uart_pkg.sv
// rz_uart_pkg: shared constants, RX state encoding and sizing helpers for the
// RZ UART. Build option RZ_UART_PARITY_EN adds an even-parity bit to each frame.
`timescale 1ns/1ps
package rz_uart_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  // Number of bit slots in one frame: start + data (+ parity) + stop.
  function automatic int frame_bits(input int data_width);
`ifdef RZ_UART_PARITY_EN
    return data_width + 3;
`else
    return data_width + 2;
`endif
  endfunction

  // Width of a counter that must hold the values 0 .. n-1.
  function automatic int count_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int FRAME_BITS = frame_bits(DEFAULT_DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
`ifdef RZ_UART_PARITY_EN
    PARITY,
`endif
    STOP
  } rx_state_t;

endpackage

// File: rtl/rz_uart_if.sv
// rz_uart_if: word-level transmit request and receive result of the RZ UART.
// The core is the slave; the user logic is the master. Frame layout depends
// on RZ_UART_PARITY_EN but the word-level signals do not.
`timescale 1ns/1ps
interface rz_uart_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  tx_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] rx_data;

  modport master (
    output tx_valid,
    output tx_data,
    input  rx_valid,
    input  rx_data
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output rx_valid,
    output rx_data
  );
endinterface

// File: rtl/rz_uart_rx.sv
// rz_uart_rx: self-timed RZ receiver. Every rising edge of (rx_p | rx_n) is a
// bit strobe and rx_p at that moment is the bit value, so no receive clock is
// needed. With RZ_UART_PARITY_EN defined an even-parity slot is checked
// before the stop bit and a mismatch discards the frame.
`timescale 1ns/1ps
module rz_uart_rx
  import rz_uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  reset_n,
  input  logic                  rx_p,
  input  logic                  rx_n,
  output logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] rx_data
);

  localparam int CNT_W = count_width(DATA_WIDTH);

  logic                  strobe;
  logic                  bit_val;
  rx_state_t             state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
`ifdef RZ_UART_PARITY_EN
  logic                  parity_ok;
`endif

  assign strobe  = rx_p | rx_n;
  assign bit_val = rx_p;

  // Frame FSM clocked by the incoming pulses themselves.
  always_ff @(posedge strobe or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
`ifdef RZ_UART_PARITY_EN
      parity_ok <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!bit_val) begin
            rx_valid <= 1'b0;
            bit_cnt  <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          shift_reg[bit_cnt] <= bit_val;
          if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
`ifdef RZ_UART_PARITY_EN
            state <= PARITY;
`else
            state <= STOP;
`endif
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
`ifdef RZ_UART_PARITY_EN
        PARITY: begin
          parity_ok <= (bit_val == (^shift_reg));
          state     <= STOP;
        end
`endif
        STOP: begin
`ifdef RZ_UART_PARITY_EN
          if (bit_val && parity_ok) begin
`else
          if (bit_val) begin
`endif
            rx_data  <= shift_reg;
            rx_valid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rz_uart_core.sv
// rz_uart_core: full-duplex UART over differential return-to-zero pairs.
// TX runs on tx_clk, two cycles per bit (pulse, then both-low); a request is
// accepted with zero latency whenever TX is idle. RX is self-timed in
// rz_uart_rx. Build option RZ_UART_PARITY_EN inserts an even-parity bit.
`timescale 1ns/1ps
module rz_uart_core
  import rz_uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic      tx_clk,
  input  logic      reset_n,
  input  logic      rx_p,
  input  logic      rx_n,
  output logic      tx_p,
  output logic      tx_n,
  rz_uart_if.slave  bus
);

  localparam int F     = frame_bits(DATA_WIDTH);
  localparam int CNT_W = count_width(2 * F);

  logic             busy;
  logic [CNT_W-1:0] cyc;
  logic [F-1:0]     frame_sr;
  logic [F-1:0]     next_frame;

  // Frame assembled from the request word, transmitted LSB (start bit) first.
  always_comb begin
`ifdef RZ_UART_PARITY_EN
    next_frame = {1'b1, ^bus.tx_data, bus.tx_data, 1'b0};
`else
    next_frame = {1'b1, bus.tx_data, 1'b0};
`endif
  end

  // TX sequencer: odd cycle counts are the both-low half of each bit.
  always_ff @(posedge tx_clk or negedge reset_n) begin
    if (!reset_n) begin
      busy     <= 1'b0;
      cyc      <= '0;
      frame_sr <= '0;
      tx_p     <= 1'b0;
      tx_n     <= 1'b0;
    end else if (!busy) begin
      if (bus.tx_valid) begin
        busy     <= 1'b1;
        cyc      <= CNT_W'(1);
        frame_sr <= next_frame;
        tx_p     <= next_frame[0];
        tx_n     <= ~next_frame[0];
      end else begin
        tx_p <= 1'b0;
        tx_n <= 1'b0;
      end
    end else if (cyc[0]) begin
      tx_p     <= 1'b0;
      tx_n     <= 1'b0;
      frame_sr <= frame_sr >> 1;
      if (cyc == CNT_W'(2 * F - 1)) begin
        busy <= 1'b0;
        cyc  <= '0;
      end else begin
        cyc <= cyc + CNT_W'(1);
      end
    end else begin
      tx_p <= frame_sr[0];
      tx_n <= ~frame_sr[0];
      cyc  <= cyc + CNT_W'(1);
    end
  end

  rz_uart_rx #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rx (
    .reset_n  (reset_n),
    .rx_p     (rx_p),
    .rx_n     (rx_n),
    .rx_valid (bus.rx_valid),
    .rx_data  (bus.rx_data)
  );

endmodule

// File: tb/tb_rz_uart_core.sv
// tb_rz_uart_core: directed bench for rz_uart_core. Instance a is driven on
// its RX pair by the bench; its TX pair feeds the RX of instance b, forming a
// loopback. Frame layout follows RZ_UART_PARITY_EN when it is defined.
`timescale 1ns/1ps
module tb_rz_uart_core;
  import rz_uart_pkg::*;

  localparam int DW = 8;
  localparam int F  = FRAME_BITS;

  logic tx_clk = 1'b0;
  logic reset_n = 1'b1;
  logic rx_p_drv = 1'b0;
  logic rx_n_drv = 1'b0;
  logic tx_p_a, tx_n_a, tx_p_b, tx_n_b;

  int checks = 0;
  int errors = 0;

  rz_uart_if #(.DATA_WIDTH(DW)) bus_a ();
  rz_uart_if #(.DATA_WIDTH(DW)) bus_b ();

  rz_uart_core #(.DATA_WIDTH(DW)) dut_a (
    .tx_clk  (tx_clk),
    .reset_n (reset_n),
    .rx_p    (rx_p_drv),
    .rx_n    (rx_n_drv),
    .tx_p    (tx_p_a),
    .tx_n    (tx_n_a),
    .bus     (bus_a)
  );

  rz_uart_core #(.DATA_WIDTH(DW)) dut_b (
    .tx_clk  (tx_clk),
    .reset_n (reset_n),
    .rx_p    (tx_p_a),
    .rx_n    (tx_n_a),
    .tx_p    (tx_p_b),
    .tx_n    (tx_n_b),
    .bus     (bus_b)
  );

  // 100 MHz transmit clock.
  always #5 tx_clk = ~tx_clk;

  // Stop the run if something never finishes.
  initial begin
    #3ms;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [F-1:0] tx_frame(input logic [DW-1:0] d);
`ifdef RZ_UART_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b1, d, 1'b0};
`endif
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One RZ pulse followed by an equal both-low gap.
  task automatic rx_pulse(input logic p, input logic n, input int period_ps);
    rx_p_drv = p;
    rx_n_drv = n;
    #(period_ps / 2000.0);
    rx_p_drv = 1'b0;
    rx_n_drv = 1'b0;
    #(period_ps / 2000.0);
  endtask

  // Everything after the start bit: data LSB first, optional parity, stop.
  task automatic rx_tail(input logic [DW-1:0] d, input int period_ps,
                         input logic stop_p, input logic stop_n);
    for (int i = 0; i < DW; i++) rx_pulse(d[i], ~d[i], period_ps);
`ifdef RZ_UART_PARITY_EN
    rx_pulse(^d, ~(^d), period_ps);
`endif
    rx_pulse(stop_p, stop_n, period_ps);
  endtask

  // Request a word on instance a at a negedge; returns at the negedge after
  // the last cycle of its frame.
  task automatic apply_stimulus(input logic [DW-1:0] d);
    bus_a.tx_valid = 1'b1;
    bus_a.tx_data  = d;
    @(posedge tx_clk);
    @(negedge tx_clk);
    bus_a.tx_valid = 1'b0;
    repeat (2 * F - 1) @(negedge tx_clk);
  endtask

  logic [DW-1:0] lb_words [10] = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h5A,
                                   8'hC3, 8'h7E, 8'h24, 8'h99, 8'h3F};
  logic [DW-1:0] rx_words [10] = '{8'h3C, 8'hA1, 8'h0F, 8'hF0, 8'h66,
                                   8'h81, 8'hE7, 8'h18, 8'hB4, 8'h4B};
  int            rx_per   [10] = '{1000000, 1000, 5000000, 2000, 333000,
                                   10000, 77000, 4000000, 1500, 250000};

  initial begin
    logic [F-1:0] fr;
    logic [1:0]   exp_pn;

    bus_a.tx_valid = 1'b0;
    bus_a.tx_data  = '0;
    bus_b.tx_valid = 1'b0;
    bus_b.tx_data  = '0;

    // Reset values.
    #1 reset_n = 1'b0;
    repeat (3) @(negedge tx_clk);
    check_output("rst_tx_pn", {tx_p_a, tx_n_a}, 2'b00);
    check_output("rst_rx_valid", bus_a.rx_valid, 1'b0);
    check_output("rst_rx_data", bus_a.rx_data, 8'h00);
    check_output("rst_b_rx_valid", bus_b.rx_valid, 1'b0);
    reset_n = 1'b1;
    repeat (2) @(negedge tx_clk);
    check_output("idle_tx_pn", {tx_p_a, tx_n_a}, 2'b00);

    // Single TX frame of 0xA5, cycle by cycle, then idle at cycle 2F.
    $display("[TB] TX single frame");
    fr = tx_frame(8'hA5);
    bus_a.tx_valid = 1'b1;
    bus_a.tx_data  = 8'hA5;
    for (int k = 0; k <= 2 * F; k++) begin
      @(posedge tx_clk);
      @(negedge tx_clk);
      if (k == 0) bus_a.tx_valid = 1'b0;
      if (k >= 2 * F || k % 2 == 1) exp_pn = 2'b00;
      else exp_pn = {fr[k/2], ~fr[k/2]};
      check_output($sformatf("tx_cyc%0d", k), {tx_p_a, tx_n_a}, exp_pn);
    end
    check_output("lb_a5_valid", bus_b.rx_valid, 1'b1);
    check_output("lb_a5_data", bus_b.rx_data, 8'hA5);

    // Loopback of ten words into instance b.
    $display("[TB] TX loopback");
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(lb_words[i]);
      check_output($sformatf("lb%0d_valid", i), bus_b.rx_valid, 1'b1);
      check_output($sformatf("lb%0d_data", i), bus_b.rx_data, lb_words[i]);
    end

    // Busy: 0x22 requested during the 0x11 frame waits until cycle 2F.
    $display("[TB] TX busy");
    repeat (2) @(negedge tx_clk);
    bus_a.tx_valid = 1'b1;
    bus_a.tx_data  = 8'h11;
    @(posedge tx_clk);
    @(negedge tx_clk);
    bus_a.tx_valid = 1'b0;
    repeat (2) @(posedge tx_clk);
    @(negedge tx_clk);
    bus_a.tx_valid = 1'b1;
    bus_a.tx_data  = 8'h22;
    repeat (2 * F - 3) @(negedge tx_clk);
    check_output("busy_first_valid", bus_b.rx_valid, 1'b1);
    check_output("busy_first_data", bus_b.rx_data, 8'h11);
    @(posedge tx_clk);
    @(negedge tx_clk);
    bus_a.tx_valid = 1'b0;
    check_output("busy_b2b_start", {tx_p_a, tx_n_a}, 2'b01);
    check_output("busy_b2b_valid_drop", bus_b.rx_valid, 1'b0);
    repeat (2 * F - 1) @(negedge tx_clk);
    check_output("busy_second_valid", bus_b.rx_valid, 1'b1);
    check_output("busy_second_data", bus_b.rx_data, 8'h22);

    // RX at widely varying bit periods; valid drops at each next start bit.
    $display("[TB] RX variable rate");
    for (int i = 0; i < 10; i++) begin
      rx_pulse(1'b0, 1'b1, rx_per[i]);
      if (i > 0) begin
        check_output($sformatf("rx%0d_start_drop", i), bus_a.rx_valid, 1'b0);
        check_output($sformatf("rx%0d_hold", i), bus_a.rx_data, rx_words[i-1]);
      end
      rx_tail(rx_words[i], rx_per[i], 1'b1, 1'b0);
      check_output($sformatf("rx%0d_valid", i), bus_a.rx_valid, 1'b1);
      check_output($sformatf("rx%0d_data", i), bus_a.rx_data, rx_words[i]);
    end

    // A lone '1' pulse while idle is ignored.
    rx_pulse(1'b1, 1'b0, 20000);
    check_output("resync_valid", bus_a.rx_valid, 1'b1);
    check_output("resync_data", bus_a.rx_data, 8'h4B);

    // Framing error, then a good frame whose stop bit has both wires high.
    $display("[TB] RX framing error");
    rx_pulse(1'b0, 1'b1, 20000);
    rx_tail(8'h55, 20000, 1'b0, 1'b1);
    check_output("ferr_valid", bus_a.rx_valid, 1'b0);
    check_output("ferr_data", bus_a.rx_data, 8'h4B);
    rx_pulse(1'b0, 1'b1, 20000);
    rx_tail(8'h12, 20000, 1'b1, 1'b1);
    check_output("after_ferr_valid", bus_a.rx_valid, 1'b1);
    check_output("after_ferr_data", bus_a.rx_data, 8'h12);

    // Reset in the middle of a TX frame and an RX frame.
    $display("[TB] reset mid-frame");
    @(negedge tx_clk);
    bus_a.tx_valid = 1'b1;
    bus_a.tx_data  = 8'hFF;
    @(posedge tx_clk);
    @(negedge tx_clk);
    bus_a.tx_valid = 1'b0;
    rx_pulse(1'b0, 1'b1, 20);
    rx_pulse(1'b1, 1'b0, 20);
    @(posedge tx_clk);
    #1 reset_n = 1'b0;
    #1;
    check_output("mid_rst_tx_pn", {tx_p_a, tx_n_a}, 2'b00);
    check_output("mid_rst_rx_valid", bus_a.rx_valid, 1'b0);
    check_output("mid_rst_rx_data", bus_a.rx_data, 8'h00);
    check_output("mid_rst_b_data", bus_b.rx_data, 8'h00);
    @(negedge tx_clk);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge tx_clk);
      check_output($sformatf("post_rst_idle%0d", k), {tx_p_a, tx_n_a}, 2'b00);
    end
    check_output("post_rst_b_valid", bus_b.rx_valid, 1'b0);
    rx_pulse(1'b0, 1'b1, 20000);
    rx_tail(8'h5A, 20000, 1'b1, 1'b0);
    check_output("post_rst_rx_valid", bus_a.rx_valid, 1'b1);
    check_output("post_rst_rx_data", bus_a.rx_data, 8'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rz_uart_core.md
Name: rz_uart_core

Overview:
- Full-duplex UART over a differential return-to-zero (RZ) pair, one pair per direction.
- Bit encoding on each pair:
  - Bit '1' is a pulse on the _p wire.
  - Bit '0' is a pulse on the _n wire.
  - Each pulse is followed by an interval with both wires low.
- TX is synchronous to tx_clk. RX is self-timed from the incoming pulses, so no receive clock is needed and any bit rate is accepted.
- The block sits at the chip/board serial link boundary. Two instances connected TX-to-RX form a loopback.

Parameters:
- DATA_WIDTH, 8, number of payload bits per frame.

Ports:
- tx_clk  in  1  single clock; drives the TX path.
- reset_n  in  1  asynchronous active-low reset for all state, TX and RX.
- rx_p  in  1  RZ receive positive wire.
- rx_n  in  1  RZ receive negative wire.
- rx_valid  out  1  high while rx_data holds a completed frame.
- rx_data  out  DATA_WIDTH  last correctly framed received word.
- tx_valid  in  1  transmit request, sampled on posedge tx_clk.
- tx_data  in  DATA_WIDTH  word to transmit, captured with tx_valid.
- tx_p  out  1  RZ transmit positive wire, registered.
- tx_n  out  1  RZ transmit negative wire, registered.

Behaviour:
- Frame format (both directions):
  - start bit (0), then DATA_WIDTH data bits LSB first, then stop bit (1).
  - Frame length F = DATA_WIDTH+2 bits.
- Reset (asynchronous):
  - tx_p=0, tx_n=0, TX idle.
  - RX idle, rx_valid=0, rx_data=0.
- TX:
  - Each bit occupies 2 tx_clk cycles:
    - phase A: tx_p=bit, tx_n=~bit.
    - phase B: tx_p=tx_n=0.
  - Accept edge: a posedge where TX is idle and tx_valid=1.
    - tx_data is latched.
    - Phase A of the start bit (tx_n=1) appears on that same edge, i.e. zero extra latency.
  - Frame lasts 2*F cycles (20 for the default width). TX becomes idle after phase B of the stop bit.
  - A request on the edge immediately following the last phase B is accepted, so frames can be back-to-back.
  - tx_valid while busy is ignored. No queue, no busy output.
  - tx_p and tx_n are never high together.
- RX strobe and bit value:
  - Strobe = rising edge of (rx_p | rx_n).
  - Bit value = rx_p at the strobe.
  - Both wires high at once is treated as '1'.
  - Widths and gaps are unconstrained. Any period is accepted provided each pulse is followed by a both-low interval.
- RX states:
  - IDLE:
    - strobe with '0' → clear rx_valid, go to DATA with bit count 0.
    - strobe with '1' → ignored, for resynchronisation.
  - DATA: shift rx_p into position count; after DATA_WIDTH bits go to STOP.
  - STOP:
    - '1' → rx_data <= shift register, rx_valid <= 1, go to IDLE.
    - '0' → framing error: frame discarded, rx_data unchanged, rx_valid stays 0, go to IDLE.
- rx_valid timing:
  - Rises at the stop-bit strobe.
  - Remains high until the next start-bit strobe or reset.
  - rx_data is stable whenever rx_valid=1.
- RX outputs are not synchronised to tx_clk; consumers must synchronise them.
- Reset mid-frame on either path aborts the frame immediately. No partial output.

Optional Feature:
- Macro RZ_UART_PARITY_EN.
- Defined:
  - An even-parity bit is inserted between the last data bit and the stop bit, so F = DATA_WIDTH+3 and a TX frame is 2*F cycles.
  - RX checks parity. On mismatch the frame is discarded like a framing error.
- Undefined: frame as above, no parity logic.

Decomposition:
- Package rz_uart_pkg holds:
  - FRAME_BITS constant derived from DATA_WIDTH and the parity macro.
  - RX state enum (IDLE, DATA, STOP, plus PARITY under the macro).
  - Bit-count width function.
- One natural sub-module, rz_uart_rx: the self-timed receiver.
- TX is a counter plus shift register inside the top level.

Test Plan:
- Reset: hold reset_n=0 → tx_p=tx_n=0, rx_valid=0, rx_data=0.
- TX single: tx_valid one cycle with 0xA5 → on accept edge tx_n=1. Next 18 half-bit cycles give bits 1,0,1,0,0,1,0,1, then stop tx_p=1. Idle from cycle 20.
- TX loopback: drive tx_p/tx_n into a second instance's rx, 10 random words → each word appears on its rx_data when its rx_valid rises.
- RX variable rate: 10 frames with random bit periods from 1 ns to 5 µs, e.g. 0x3C at 1 µs/bit → rx_valid=1, rx_data=0x3C. rx_valid drops at the next start bit.
- RX framing error: frame 0x55 with stop bit 0 → rx_valid stays 0, rx_data keeps its previous value. Next good frame 0x12 is received correctly.
- TX busy: tx_valid=1 with 0x11, then 0x22 three cycles later → only 0x11 is transmitted. 0x22 asserted at cycle 20 is transmitted back-to-back.
